stream_arbiter_qos: RTL and testbench

//  N-to-1 packet arbiter for valid/ready streams. Grants the output to the valid stream with the highest QoS.

---
 rtl/stream_arb_pkg.sv | 7 +
 rtl/qos_winner_select.sv | 36 +++
 rtl/stream_arbiter_qos.sv | 76 +++++++
 tb/tb_stream_arbiter_qos.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared FSM state type and priority sizing for the QoS stream arbiter.
package stream_arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  function automatic int prio_width(input int qos_width);
    return qos_width + 1;
  endfunction
endpackage

// File: rtl/qos_winner_select.sv
// qos_winner_select: picks the valid stream with the highest effective QoS, round-robin among ties.
module qos_winner_select
  import stream_arb_pkg::*;
#(
  parameter int QOS_WIDTH    = 4,
  parameter int STREAM_COUNT = 2,
  parameter int ID_WIDTH     = $clog2(STREAM_COUNT)
) (
  input  logic [STREAM_COUNT-1:0][QOS_WIDTH-1:0] qos,
  input  logic [STREAM_COUNT-1:0]                valid,
  input  logic [ID_WIDTH-1:0]                    rr_ptr,
  output logic [ID_WIDTH-1:0]                    winner_id,
  output logic                                   any_valid
);
  localparam int PW = prio_width(QOS_WIDTH);
  logic [PW-1:0] best;
  logic [ID_WIDTH-1:0] idx;
  // qos 0 maps above every nonzero qos
  function automatic logic [PW-1:0] eff_prio(input logic [QOS_WIDTH-1:0] q);
    return (q == '0) ? {1'b1, {QOS_WIDTH{1'b0}}} : {1'b0, q};
  endfunction
  // scan starts just after rr_ptr; strict > keeps the earliest cyclic candidate on ties
  always_comb begin
    winner_id = '0;
    best = '0;
    idx = '0;
    any_valid = |valid;
    for (int k = 1; k <= STREAM_COUNT; k++) begin
      idx = ID_WIDTH'((int'(rr_ptr) + k) % STREAM_COUNT);
      if (valid[idx] && eff_prio(qos[idx]) > best) begin
        best = eff_prio(qos[idx]);
        winner_id = idx;
      end
    end
  end
endmodule

// File: rtl/stream_arbiter_qos.sv
// stream_arbiter_qos: N-to-1 packet arbiter, QoS priority with round-robin ties, registered output.
module stream_arbiter_qos
  import stream_arb_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int QOS_WIDTH    = 4,
  parameter int STREAM_COUNT = 2,
  parameter int ID_WIDTH     = $clog2(STREAM_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [STREAM_COUNT-1:0][QOS_WIDTH-1:0]    s_qos_i,
  input  logic [STREAM_COUNT-1:0]                   s_last_i,
  input  logic [STREAM_COUNT-1:0]                   s_valid_i,
  output logic [STREAM_COUNT-1:0]                   s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic [QOS_WIDTH-1:0]                      m_qos_o,
  output logic [ID_WIDTH-1:0]                       m_id_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i
);
  arb_state_t state, state_nxt;
  logic [ID_WIDTH-1:0] grant, rr_ptr, winner_id;
  logic [QOS_WIDTH-1:0] pkt_qos;
  logic any_valid, take, accept;
  qos_winner_select #(
    .QOS_WIDTH(QOS_WIDTH),
    .STREAM_COUNT(STREAM_COUNT),
    .ID_WIDTH(ID_WIDTH)
  ) u_sel (
    .qos(s_qos_i),
    .valid(s_valid_i),
    .rr_ptr(rr_ptr),
    .winner_id(winner_id),
    .any_valid(any_valid)
  );
  always_comb begin
    take = (state == LOCKED) && (!m_valid_o || m_ready_i);
    accept = take && s_valid_i[grant];
    s_ready_o = take ? STREAM_COUNT'(1) << grant : '0;
    state_nxt = (state == IDLE) ? (any_valid ? LOCKED : IDLE) :
                ((accept && s_last_i[grant]) ? IDLE : LOCKED);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // packet qos is latched at arbitration so the output beat fields only change on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      rr_ptr <= ID_WIDTH'(STREAM_COUNT - 1);
      pkt_qos <= '0;
      m_data_o <= '0;
      m_qos_o <= '0;
      m_id_o <= '0;
      m_last_o <= 1'b0;
      m_valid_o <= 1'b0;
    end else begin
      if (state == IDLE && any_valid) begin
        grant <= winner_id;
        rr_ptr <= winner_id;
        pkt_qos <= s_qos_i[winner_id];
      end
      if (accept) begin
        m_data_o <= s_data_i[grant];
        m_qos_o <= pkt_qos;
        m_id_o <= grant;
        m_last_o <= s_last_i[grant];
        m_valid_o <= 1'b1;
      end else if (m_ready_i) m_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_arbiter_qos.sv
// tb_stream_arbiter_qos: queue-fed sources, scoreboard of expected output beats, vector table plus corner sequences.
module tb_stream_arbiter_qos;
  typedef struct { logic [7:0] data; logic last; logic [3:0] qos; } beat_t;
  typedef struct { logic id; logic [3:0] qos; logic [7:0] data; logic last; } exp_t;
  typedef struct { logic [3:0] q0; logic [3:0] q1; int len0; int len1; logic first; } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][7:0] s_data_i;
  logic [1:0][3:0] s_qos_i;
  logic [1:0] s_last_i, s_valid_i, s_ready_o, fire;
  logic [7:0] m_data_o;
  logic [3:0] m_qos_o;
  logic m_id_o, m_last_o, m_valid_o, m_ready_i;
  int checks = 0, errors = 0, cyc = 0, last_pop = 0;
  bit rec = 0;
  int gaps[$];
  beat_t q0[$], q1[$];
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] seq = 8'd0;
  vec_t vecs[8];
  stream_arbiter_qos dut (
    .clk(clk), .rst_n(rst_n), .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .m_data_o(m_data_o), .m_qos_o(m_qos_o),
    .m_id_o(m_id_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic present();
    s_valid_i[0] = q0.size() != 0;
    s_data_i[0] = (q0.size() != 0) ? q0[0].data : 8'd0;
    s_last_i[0] = (q0.size() != 0) ? q0[0].last : 1'b0;
    s_qos_i[0] = (q0.size() != 0) ? q0[0].qos : 4'd0;
    s_valid_i[1] = q1.size() != 0;
    s_data_i[1] = (q1.size() != 0) ? q1[0].data : 8'd0;
    s_last_i[1] = (q1.size() != 0) ? q1[0].last : 1'b0;
    s_qos_i[1] = (q1.size() != 0) ? q1[0].qos : 4'd0;
  endtask
  // sources: a beat leaves its queue once valid&ready was seen for that cycle
  initial begin
    present();
    forever begin
      @(negedge clk);
      fire = s_valid_i & s_ready_o;
      @(posedge clk);
      #1;
      if (fire[0] && q0.size() != 0) void'(q0.pop_front());
      if (fire[1] && q1.size() != 0) void'(q1.pop_front());
      present();
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n && m_valid_o && m_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got id=%0d qos=%0d data=%0h last=%0b, expected no beat",
                 m_id_o, m_qos_o, m_data_o, m_last_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_id_o !== mon_e.id || m_qos_o !== mon_e.qos || m_data_o !== mon_e.data || m_last_o !== mon_e.last) begin
          errors++;
          $display("FAIL beat: got id=%0d qos=%0d data=%0h last=%0b, expected id=%0d qos=%0d data=%0h last=%0b",
                   m_id_o, m_qos_o, m_data_o, m_last_o, mon_e.id, mon_e.qos, mon_e.data, mon_e.last);
        end
      end
      if (rec) gaps.push_back(cyc - last_pop);
      last_pop = cyc;
    end
  end
  task automatic add_pkt(input int s, input logic [3:0] q, input logic [3:0] qmid, input int len);
    beat_t b;
    exp_t e;
    for (int i = 0; i < len; i++) begin
      b.data = seq;
      b.last = (i == len - 1);
      b.qos = (i == 0) ? q : qmid;
      e.id = (s != 0);
      e.qos = q;
      e.data = seq;
      e.last = b.last;
      if (s == 0) q0.push_back(b);
      else q1.push_back(b);
      exp_q.push_back(e);
      seq++;
    end
  endtask
  task automatic drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic wait_data(input string name, input logic [7:0] d);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = m_valid_o && m_data_o == d;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_wait: data %0h never appeared, got %0h valid=%0b", name, d, m_data_o, m_valid_o);
    end
  endtask
  task automatic check_idle_outputs(input string name);
    checks++;
    if (s_ready_o !== 2'b00 || m_valid_o !== 1'b0 || m_data_o !== 8'd0 || m_qos_o !== 4'd0 ||
        m_id_o !== 1'b0 || m_last_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: got ready=%b valid=%b data=%0h qos=%0d id=%0d last=%b, expected all 0",
               name, s_ready_o, m_valid_o, m_data_o, m_qos_o, m_id_o, m_last_o);
    end
  endtask
  initial begin
    logic [7:0] base;
    vecs[0] = '{q0: 4'd3,  q1: 4'd7,  len0: 2, len1: 2, first: 1'b1};
    vecs[1] = '{q0: 4'd0,  q1: 4'd15, len0: 2, len1: 1, first: 1'b0};
    vecs[2] = '{q0: 4'd15, q1: 4'd0,  len0: 1, len1: 3, first: 1'b1};
    vecs[3] = '{q0: 4'd9,  q1: 4'd9,  len0: 2, len1: 1, first: 1'b1};
    vecs[4] = '{q0: 4'd2,  q1: 4'd1,  len0: 1, len1: 1, first: 1'b0};
    vecs[5] = '{q0: 4'd4,  q1: 4'd4,  len0: 3, len1: 2, first: 1'b0};
    vecs[6] = '{q0: 4'd0,  q1: 4'd0,  len0: 1, len1: 2, first: 1'b0};
    vecs[7] = '{q0: 4'd1,  q1: 4'd15, len0: 2, len1: 2, first: 1'b1};
    rst_n = 1'b0;
    m_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle_after_reset");
    foreach (vecs[r]) begin
      if (vecs[r].first) begin
        add_pkt(1, vecs[r].q1, vecs[r].q1, vecs[r].len1);
        add_pkt(0, vecs[r].q0, vecs[r].q0, vecs[r].len0);
      end else begin
        add_pkt(0, vecs[r].q0, vecs[r].q0, vecs[r].len0);
        add_pkt(1, vecs[r].q1, vecs[r].q1, vecs[r].len1);
      end
      drain("table", 200);
    end
    // equal qos single-beat packets: strict alternation, one arbitration cycle between beats
    @(negedge clk);
    gaps.delete();
    for (int i = 0; i < 4; i++) begin
      add_pkt(1, 4'd5, 4'd5, 1);
      add_pkt(0, 4'd5, 4'd5, 1);
    end
    rec = 1;
    drain("alternate", 200);
    rec = 0;
    for (int i = 1; i < gaps.size(); i++) begin
      checks++;
      if (gaps[i] != 2) begin
        errors++;
        $display("FAIL alternate_gap[%0d]: got %0d cycles, expected 2", i, gaps[i]);
      end
    end
    // output stall on beat 2 for three cycles
    @(negedge clk);
    base = seq;
    add_pkt(0, 4'd6, 4'd6, 4);
    wait_data("stall", base + 8'd1);
    m_ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (!m_valid_o || m_data_o !== base + 8'd1 || s_ready_o !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b data=%0h ready=%b, expected valid=1 data=%0h ready=00",
                 m_valid_o, m_data_o, s_ready_o, base + 8'd1);
      end
    end
    @(posedge clk);
    #1 m_ready_i = 1'b1;
    drain("stall", 200);
    // higher qos arrival and qos change on the locked stream must not break the packet
    @(negedge clk);
    base = seq;
    add_pkt(0, 4'd1, 4'd0, 4);
    wait_data("lock", base + 8'd1);
    @(negedge clk);
    add_pkt(1, 4'd15, 4'd15, 2);
    drain("lock", 200);
    // reset during beat 2 discards the packet; fresh tie arbitration starts from rr_ptr=1
    @(negedge clk);
    base = seq;
    add_pkt(0, 4'd3, 4'd3, 3);
    wait_data("midreset", base + 8'd1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset_outputs");
    q0.delete();
    q1.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    add_pkt(0, 4'd2, 4'd2, 1);
    add_pkt(1, 4'd2, 4'd2, 1);
    drain("after_reset", 200);
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
